// File: rtl/rtc_ts_capture_pkg.sv
// Shared PTP time types and constants for the event timestamp unit.
// Latency: none (types and a combinational helper only).
// Backpressure: not applicable.
package rtc_ts_capture_pkg;

  localparam int PTP_SEC_W = 48;
  localparam int PTP_NS_W  = 32;
  localparam int TS_W      = PTP_SEC_W + PTP_NS_W;
  localparam int CNT_W     = 7;

  // Nanosecond field rolls over at this value; must match the RTC.
  localparam logic [PTP_NS_W-1:0] NS_MODULO = 32'd1_000_000_000;

  typedef struct packed {
    logic [PTP_SEC_W-1:0] sec;
    logic [PTP_NS_W-1:0]  ns;
  } ts_t;

  // Move a captured time back by comp_ns. When the ns field would go negative
  // it borrows one second; seconds wrap modulo 2^48. Sum kept in 33 bits so
  // ns + NS_MODULO cannot overflow before the subtraction.
  function automatic ts_t ts_compensate(input ts_t cap, input logic [PTP_NS_W-1:0] comp_ns);
    logic [PTP_NS_W:0] ns_ext;
    ts_t               res;
    res = cap;
    if (cap.ns >= comp_ns) begin
      ns_ext = {1'b0, cap.ns} - {1'b0, comp_ns};
    end else begin
      ns_ext  = {1'b0, cap.ns} + {1'b0, NS_MODULO} - {1'b0, comp_ns};
      res.sec = cap.sec - 48'd1;
    end
    res.ns = ns_ext[PTP_NS_W-1:0];
    return res;
  endfunction

endpackage

// File: rtl/rtc_ts_capture_if.sv
// CPU-facing timestamp queue interface: pop/flush/clear controls and head entry.
// Latency: none (wires only).
// Backpressure: none; the CPU pops with q_rd, the unit drops captures when full.
//  master: CPU side (drives q_rd, q_flush, q_ovf_clr)
//  slave : timestamp unit (drives q_sec, q_ns, q_empty, q_full, q_cnt, q_ovf)
interface rtc_ts_capture_if;
  import rtc_ts_capture_pkg::*;

  logic                 q_flush;
  logic                 q_rd;
  logic                 q_ovf_clr;
  logic [PTP_SEC_W-1:0] q_sec;
  logic [PTP_NS_W-1:0]  q_ns;
  logic                 q_empty;
  logic                 q_full;
  logic [CNT_W-1:0]     q_cnt;
  logic                 q_ovf;

  modport master (
    output q_flush, q_rd, q_ovf_clr,
    input  q_sec, q_ns, q_empty, q_full, q_cnt, q_ovf
  );

  modport slave (
    input  q_flush, q_rd, q_ovf_clr,
    output q_sec, q_ns, q_empty, q_full, q_cnt, q_ovf
  );

endinterface

// File: rtl/rtc_ts_capture_fifo.sv
// Synchronous FIFO with registered head output, flush and occupancy count.
// Latency: push visible (empty low, dout valid) one cycle after wr.
// Backpressure: push while full is ignored unless a pop happens the same cycle.
//  clk/rst : clock, synchronous active-low reset
//  wr/din  : push request and data;  rd : pop request (ignored when empty)
//  flush   : empty the FIFO, beats wr and rd
//  dout    : registered head entry;  full/empty/cnt : status
module rtc_ts_capture_fifo #(
  parameter int DATA_W = 80,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic [DATA_W-1:0] din,
  input  logic              rd,
  input  logic              flush,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr, rd_ptr_inc, occ;
  logic              do_wr, do_rd;

  // Extra pointer MSB tells full from empty; pointers wrap naturally.
  assign occ        = wr_ptr - rd_ptr;
  assign rd_ptr_inc = rd_ptr + PW'(1);
  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign cnt        = CNT_W'(occ);

  assign do_rd = rd & ~empty;
  assign do_wr = wr & (~full | do_rd);

  always_ff @(posedge clk) begin
    if (do_wr && !flush) begin
      mem[wr_ptr[AW-1:0]] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      dout   <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PW'(1);
      if (do_rd) rd_ptr <= rd_ptr_inc;
      // Head register: after a pop take the next stored entry, or the entry
      // being written if the pop leaves only that one; a push into an empty
      // FIFO loads the head directly.
      if (do_rd) begin
        if (occ == PW'(1)) begin
          if (do_wr) dout <= din;
        end else begin
          dout <= mem[rd_ptr_inc[AW-1:0]];
        end
      end else if (do_wr && empty) begin
        dout <= din;
      end
    end
  end

endmodule

// File: rtl/rtc_ts_capture.sv
// Timestamps qualified edges of an async event with RTC time, minus a fixed latency.
// Latency: edge on event_in to queue non-empty <= 6 clk (3 sync + 3 pipeline).
// Backpressure: none upstream; captures arriving at a full queue are dropped, q_ovf set.
//  clk/rst            : clock shared with the RTC, synchronous active-low reset
//  time_ptp_sec/_ns   : live RTC time
//  event_in           : asynchronous event level
//  cap_en / cap_edge  : capture enable, edge select (0 rising, 1 falling)
//  qif (slave)        : CPU queue port (pop, flush, overflow clear, head, status)
module rtc_ts_capture
  import rtc_ts_capture_pkg::*;
#(
  parameter int                  FIFO_DEPTH = 8,
  parameter logic [PTP_NS_W-1:0] COMP_NS    = 32'd3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [PTP_SEC_W-1:0] time_ptp_sec,
  input  logic [PTP_NS_W-1:0]  time_ptp_ns,
  input  logic                 event_in,
  input  logic                 cap_en,
  input  logic                 cap_edge,
  rtc_ts_capture_if.slave      qif
);

  logic s1, s2, s3;
  logic edge_hit, det;
  logic cap_v, k_v;
  ts_t  cap_ts, k_ts, head_ts;
  logic fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_cnt;
  logic ovf_q, drop;

  // s1 is the metastability flop; edges are judged on s2/s3. The chain runs
  // regardless of cap_en so enabling mid-level never fakes an edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= event_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign edge_hit = cap_edge ? (~s2 & s3) : (s2 & ~s3);
  assign det      = edge_hit & cap_en;

  // Capture stage then compensation stage; flush kills both valids.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cap_v  <= 1'b0;
      cap_ts <= '0;
      k_v    <= 1'b0;
      k_ts   <= '0;
    end else begin
      cap_v <= det & ~qif.q_flush;
      k_v   <= cap_v & ~qif.q_flush;
      if (det)   cap_ts <= '{sec: time_ptp_sec, ns: time_ptp_ns};
      if (cap_v) k_ts   <= ts_compensate(cap_ts, COMP_NS);
    end
  end

  // A full queue still accepts a push when the CPU pops in the same cycle.
  assign drop = k_v & fifo_full & ~qif.q_rd & ~qif.q_flush;

  always_ff @(posedge clk) begin
    if (!rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= drop | (ovf_q & ~qif.q_ovf_clr);
    end
  end

  rtc_ts_capture_fifo #(
    .DATA_W (TS_W),
    .DEPTH  (FIFO_DEPTH),
    .CNT_W  (CNT_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .wr    (k_v),
    .din   (k_ts),
    .rd    (qif.q_rd),
    .flush (qif.q_flush),
    .dout  (head_ts),
    .full  (fifo_full),
    .empty (fifo_empty),
    .cnt   (fifo_cnt)
  );

  assign qif.q_sec   = head_ts.sec;
  assign qif.q_ns    = head_ts.ns;
  assign qif.q_empty = fifo_empty;
  assign qif.q_full  = fifo_full;
  assign qif.q_cnt   = fifo_cnt;
  assign qif.q_ovf   = ovf_q;

endmodule

// File: tb/tb_rtc_ts_capture.sv
// Bench for rtc_ts_capture: vector table plus scoreboard of expected queue entries.
// Latency: checks edge-to-entry time and same-cycle pop/push on a full queue.
// Backpressure: exercises overflow drop, flush and reset with captures in flight.
module tb_rtc_ts_capture;
  import rtc_ts_capture_pkg::*;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [47:0] tsec;
  logic [31:0] tns;
  logic        event_in, cap_en, cap_edge;

  rtc_ts_capture_if qif();

  rtc_ts_capture #(
    .FIFO_DEPTH (DEPTH),
    .COMP_NS    (32'd3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .time_ptp_sec (tsec),
    .time_ptp_ns  (tns),
    .event_in     (event_in),
    .cap_en       (cap_en),
    .cap_edge     (cap_edge),
    .qif          (qif)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [79:0] sb[$];

  typedef struct {
    logic [47:0] sec;
    logic [31:0] ns;
    logic [47:0] exp_sec;
    logic [31:0] exp_ns;
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One rising-then-falling pulse with the RTC time held for its duration.
  task automatic fire(input logic [47:0] s, input logic [31:0] n);
    tsec     = s;
    tns      = n;
    event_in = 1'b1;
    tick(4);
    event_in = 1'b0;
    tick(4);
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 2 * DEPTH + 4; k++) begin
      if (qif.q_empty) break;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL %s: unexpected entry %0h expected none", name, {qif.q_sec, qif.q_ns});
      end else begin
        check(name, {qif.q_sec, qif.q_ns}, sb.pop_front());
      end
      qif.q_rd = 1'b1;
      tick(1);
      qif.q_rd = 1'b0;
    end
    check({name, "_left"}, 80'(sb.size()), 80'd0);
    check({name, "_empty"}, 80'(qif.q_empty), 80'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    vecs[0] = '{48'd7,  32'd1,         48'd6,              32'd999_999_998};
    vecs[1] = '{48'd0,  32'd0,         48'hFFFF_FFFF_FFFF, 32'd999_999_997};
    vecs[2] = '{48'd5,  32'd500,       48'd5,              32'd497};
    vecs[3] = '{48'd10, 32'd3,         48'd10,             32'd0};
    vecs[4] = '{48'd10, 32'd2,         48'd9,              32'd999_999_999};
    vecs[5] = '{48'd0,  32'd999999999, 48'd0,              32'd999_999_996};

    tsec = '0; tns = '0; event_in = 1'b0; cap_en = 1'b1; cap_edge = 1'b0;
    qif.q_rd = 1'b0; qif.q_flush = 1'b0; qif.q_ovf_clr = 1'b0;
    rst = 1'b0;
    tick(3);
    check("rst_empty", 80'(qif.q_empty), 80'd1);
    check("rst_full",  80'(qif.q_full),  80'd0);
    check("rst_cnt",   80'(qif.q_cnt),   80'd0);
    check("rst_ovf",   80'(qif.q_ovf),   80'd0);
    check("rst_data",  {qif.q_sec, qif.q_ns}, 80'd0);
    rst = 1'b1;
    tick(2);

    // Edge-to-entry latency and first entry.
    tsec = 48'd5; tns = 32'd500; event_in = 1'b1;
    lat = 0;
    while (qif.q_empty && lat < 10) begin
      tick(1);
      lat++;
    end
    checks++;
    if (qif.q_empty || lat > 6) begin
      errors++;
      $display("FAIL latency: got %0d cycles (empty=%0b) expected <=6", lat, qif.q_empty);
    end
    check("lat_data", {qif.q_sec, qif.q_ns}, {48'd5, 32'd497});
    check("lat_cnt", 80'(qif.q_cnt), 80'd1);
    event_in = 1'b0;
    tick(4);
    sb.push_back({48'd5, 32'd497});
    drain("t1");

    // Compensation vectors including ns borrow and seconds wrap.
    foreach (vecs[i]) begin
      fire(vecs[i].sec, vecs[i].ns);
      sb.push_back({vecs[i].exp_sec, vecs[i].exp_ns});
    end
    check("vec_cnt", 80'(qif.q_cnt), 80'd6);
    drain("vec");

    // Falling-edge mode: time differs between the two edges.
    cap_edge = 1'b1;
    tick(2);
    tsec = 48'd20; tns = 32'd100; event_in = 1'b1;
    tick(6);
    check("fall_rise_ignored", 80'(qif.q_cnt), 80'd0);
    tsec = 48'd21; tns = 32'd200; event_in = 1'b0;
    tick(6);
    sb.push_back({48'd21, 32'd197});
    check("fall_cnt", 80'(qif.q_cnt), 80'd1);
    drain("fall");

    // Disabled capture, then enable while the input is already high.
    cap_edge = 1'b0;
    cap_en   = 1'b0;
    for (int i = 0; i < 20; i++) fire(48'(30 + i), 32'd0);
    check("dis_cnt", 80'(qif.q_cnt), 80'd0);
    event_in = 1'b1;
    tick(4);
    cap_en = 1'b1;
    tick(8);
    check("reen_cnt", 80'(qif.q_cnt), 80'd0);
    event_in = 1'b0;
    tick(6);
    check("reen_fall_cnt", 80'(qif.q_cnt), 80'd0);

    // Overflow: 10 captures, only the first 8 retained.
    for (int i = 0; i < DEPTH + 2; i++) begin
      fire(48'(100 + i), 32'(1000 + i));
      if (i < DEPTH) sb.push_back({48'(100 + i), 32'(997 + i)});
    end
    check("ovf_cnt",  80'(qif.q_cnt),  80'd8);
    check("ovf_full", 80'(qif.q_full), 80'd1);
    check("ovf_flag", 80'(qif.q_ovf),  80'd1);
    qif.q_ovf_clr = 1'b1;
    tick(1);
    qif.q_ovf_clr = 1'b0;
    check("ovf_clr", 80'(qif.q_ovf), 80'd0);
    // Pop in the very cycle the compensated capture is pushed.
    tsec = 48'd200; tns = 32'd50; event_in = 1'b1;
    tick(4);
    check("rdwr_head", {qif.q_sec, qif.q_ns}, sb.pop_front());
    qif.q_rd = 1'b1;
    sb.push_back({48'd200, 32'd47});
    tick(1);
    qif.q_rd = 1'b0;
    check("rdwr_cnt",  80'(qif.q_cnt),  80'd8);
    check("rdwr_ovf",  80'(qif.q_ovf),  80'd0);
    check("rdwr_full", 80'(qif.q_full), 80'd1);
    event_in = 1'b0;
    tick(4);
    drain("ovf");

    // Pointer wrap: write 6 / read 6, then write 8 / read 8.
    for (int i = 0; i < 6; i++) begin
      fire(48'(300 + i), 32'(400 + i));
      sb.push_back({48'(300 + i), 32'(397 + i)});
    end
    drain("wrap6");
    for (int i = 0; i < DEPTH; i++) begin
      fire(48'(400 + i), 32'(500 + i));
      sb.push_back({48'(400 + i), 32'(497 + i)});
    end
    check("wrap_full", 80'(qif.q_full), 80'd1);
    drain("wrap8");

    // Flush with a capture at each point of the pipeline.
    for (int d = 2; d <= 4; d++) begin
      fire(48'd600, 32'd600);
      fire(48'd601, 32'd601);
      check("pre_flush_cnt", 80'(qif.q_cnt), 80'd2);
      tsec = 48'd602; tns = 32'd602; event_in = 1'b1;
      tick(d);
      qif.q_flush = 1'b1;
      tick(1);
      qif.q_flush = 1'b0;
      check("flush_empty", 80'(qif.q_empty), 80'd1);
      tick(8);
      check("flush_cnt", 80'(qif.q_cnt), 80'd0);
      event_in = 1'b0;
      tick(4);
    end

    // Reset with overflow set and a capture in flight.
    for (int i = 0; i < DEPTH + 1; i++) fire(48'(700 + i), 32'd700);
    check("pre_rst_ovf", 80'(qif.q_ovf), 80'd1);
    event_in = 1'b1;
    tick(3);
    rst = 1'b0;
    event_in = 1'b0;
    tick(2);
    rst = 1'b1;
    check("mrst_cnt",  80'(qif.q_cnt), 80'd0);
    check("mrst_ovf",  80'(qif.q_ovf), 80'd0);
    check("mrst_data", {qif.q_sec, qif.q_ns}, 80'd0);
    tick(10);
    check("mrst_late_cnt", 80'(qif.q_cnt), 80'd0);
    fire(48'd800, 32'd10);
    sb.push_back({48'd800, 32'd7});
    drain("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
